ex_stage_md: RTL
================

// Module: ex_stage_md
// PURPOSE
//  Parametrised MIPS execute stage with EX/MEM pipeline register. Combines a wide single-cycle ALU
//  (adds shifts, compares, ROTR, CLZ) with a multi-cycle multiply/divide unit that owns HI/LO.
//  Sits between the ID/EX register and the MEM stage. Operands arrive already forwarded.
//  Raises a stall to the hazard unit while HI/LO results are pending.
// PARAMETERS
//  XLEN     32  datapath width; must be a power of two, >= 8
//  MUL_LAT  4   cycles from MULT/MULTU acceptance to HI/LO valid (>= 1)
//  DIV_LAT  16  cycles from DIV/DIVU acceptance to HI/LO valid (>= 1)
// PORTS
//  CLK        in   1     clock
//  RESET      in   1     synchronous, active-high
//  e_valid    in   1     instruction in EX is real (0 = bubble)
//  e_alu_op   in   4     ALU op: 0 NOP,1 ADD,2 SUB,3 AND,4 OR(zero-ext imm),5 XOR,6 LUI,7 SLT,
//                        8 SLTU,9 SLL,10 SRL,11 SRA,12 ROTR,13 CLZ
//  e_md_op    in   3     0 none,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 MFHI/MFLO (see e_md_hi)
//  e_md_hi    in   1     for op 7: 1 = MFHI, 0 = MFLO
//  e_a,e_b    in   XLEN  forwarded rs / rt operands
//  e_imm      in   XLEN  extended immediate; e_alusel=1 selects it as B
//  e_alusel   in   1     B-source select
//  e_wreg     in   5     destination register (0 = no write)
//  e_pc       in   32    PC of EX instruction
//  m_valid    out  1     EX/MEM register holds a real instruction
//  m_result   out  XLEN  ALU / MFHI / MFLO result
//  m_wdata    out  XLEN  store data (= e_b, unmodified by e_alusel)
//  m_wreg     out  5     destination register
//  m_pc       out  32    PC
//  md_busy    out  1     multiply/divide in progress
//  stall_e    out  1     hold IF/ID/EX this cycle; EX/MEM receives a bubble
// BEHAVIOUR
//  - Reset: all m_* outputs 0, HI = LO = 0, FSM -> IDLE, counter 0, md_busy = stall_e = 0.
//    Reset during MUL/DIV aborts the op; HI/LO are not updated.
//  - B = e_alusel ? e_imm : e_b. Shift/rotate amount = A[log2(XLEN)-1:0]. SLL/SRL/SRA/ROTR shift B.
//  - ROTR rotates B right by that amount; amount 0 returns B.
//  - CLZ counts leading zeros of A; A = 0 gives XLEN. OR/LUI use B[15:0] (LUI = B[15:0] << 16).
//  - ADD/SUB wrap modulo 2^XLEN; no overflow trap. SLT is signed, SLTU unsigned; result is 0 or 1.
//  - FSM states: IDLE, MUL, DIV.
//    * IDLE + accepted MULT*/DIV*: capture operands, load counter with MUL_LAT-1 / DIV_LAT-1,
//      go to MUL / DIV, assert md_busy from the next cycle.
//    * MUL/DIV: counter decrements each cycle. At 0, write {HI,LO} = 2*XLEN product, or
//      LO = quotient and HI = remainder. Return to IDLE; md_busy falls the same edge.
//    * Divide: truncates toward zero (signed). Divisor 0 gives LO = all-ones, HI = dividend.
//      DIV of most-negative by -1 gives LO = dividend, HI = 0.
//  - MTHI/MTLO when IDLE: write HI/LO at the clock edge; visible to MFHI/MFLO the next cycle.
//  - stall_e = e_valid & md_busy & (e_md_op != 0). Non-HI/LO instructions proceed under md_busy.
//  - An instruction is accepted when e_valid & !stall_e. An accepted op captures into EX/MEM
//    one cycle after the EX inputs (latency 1).
//  - Stalled or invalid cycle: m_valid <= 0, m_wreg <= 0, other m_* are don't-care but are held.
//  - MFHI/MFLO in the cycle md_busy falls is not stalled and reads the new HI/LO (bypass the write).
// TESTING
//  1. Reset: assert RESET 2 cycles mid-run -> m_valid = 0, m_result = 0, md_busy = 0.
//     A following MFHI returns 0.
//  2. ALU: ROTR with A = 4, B = 0x1234_5678 -> 0x8123_4567. CLZ of 0 -> 32.
//     CLZ of 0x0001_0000 -> 15. SLT(-1, 1) -> 1. SLTU(-1, 1) -> 0.
//  3. MULT 0xFFFF_FFFF * 2 (MUL_LAT = 4), then MFLO back-to-back:
//     md_busy for 4 cycles, stall_e for 3 or 4 cycles, then MFLO -> 0xFFFF_FFFE and MFHI -> 0xFFFF_FFFF.
//  4. DIV -7 / 2 -> LO = 0xFFFF_FFFD, HI = 0xFFFF_FFFF. DIVU 5 / 0 -> LO = 0xFFFF_FFFF, HI = 5.
//  5. During DIV busy: an ADD issued -> proceeds with m_valid = 1, no stall. MTLO issued -> stalled
//     until the DIV completes, then its LO write lands after the DIV's write.
//  6. Parameter sweep XLEN = 16, MUL_LAT = 1, DIV_LAT = 1: random ops checked against a reference
//     model with cycle-exact md_busy.

Source files
------------

// File: rtl/ex_stage_md.sv
// MIPS execute stage: single-cycle ALU, multi-cycle multiply/divide unit that owns HI/LO,
// and the EX/MEM pipeline register.
//
// state | meaning
// IDLE  | no HI/LO operation in flight; MTHI/MTLO/MULT*/DIV* may be accepted
// MUL   | multiply in flight; counter runs down to 0, then {HI,LO} <= product
// DIV   | divide in flight; counter runs down to 0, then LO <= quotient, HI <= remainder
module ex_stage_md #(
   parameter int XLEN    = 32,
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 16
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            e_valid,
   input  logic [3:0]      e_alu_op,
   input  logic [2:0]      e_md_op,
   input  logic            e_md_hi,
   input  logic [XLEN-1:0] e_a,
   input  logic [XLEN-1:0] e_b,
   input  logic [XLEN-1:0] e_imm,
   input  logic            e_alusel,
   input  logic [4:0]      e_wreg,
   input  logic [31:0]     e_pc,
   output logic            m_valid,
   output logic [XLEN-1:0] m_result,
   output logic [XLEN-1:0] m_wdata,
   output logic [4:0]      m_wreg,
   output logic [31:0]     m_pc,
   output logic            md_busy,
   output logic            stall_e
);
   localparam int SHW    = $clog2(XLEN);
   localparam int MAXLAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CW     = $clog2(MAXLAT + 1);
   localparam logic [XLEN-1:0] LO16_MASK = XLEN'(64'hFFFF);
   localparam logic [SHW:0]    XLEN_W    = (SHW+1)'(XLEN);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

   state_t            r_state, w_state_nxt;
   logic [CW-1:0]     r_cnt, w_cnt_nxt;
   logic [XLEN-1:0]   r_hi, r_lo, r_op_a, r_op_b;
   logic [XLEN-1:0]   w_hi_nxt, w_lo_nxt, w_op_a_nxt, w_op_b_nxt;
   logic              r_signed, w_signed_nxt;
   logic              w_accept;

   logic [XLEN-1:0]   w_b, w_lo16, w_rotr, w_clz, w_alu, w_result;
   logic [SHW-1:0]    w_sh;
   logic [SHW:0]      w_rot_l;

   logic [2*XLEN-1:0] w_ext_a, w_ext_b, w_prod;
   logic              w_neg_a, w_neg_b;
   logic [XLEN-1:0]   w_mag_a, w_mag_b, w_div_den, w_q_mag, w_r_mag, w_quot, w_rem;

   // ---------------- ALU ----------------
   assign w_b     = e_alusel ? e_imm : e_b;
   assign w_sh    = e_a[SHW-1:0];
   assign w_lo16  = w_b & LO16_MASK;
   // Left half of the rotate uses XLEN - amount; amount 0 shifts everything out, leaving B.
   assign w_rot_l = XLEN_W - {1'b0, w_sh};
   assign w_rotr  = (w_b >> w_sh) | (w_b << w_rot_l);

   always_comb begin
      w_clz = XLEN'(XLEN);
      for (int i = 0; i < XLEN; i++)
         if (e_a[i]) w_clz = XLEN'(XLEN - 1 - i);
   end

   always_comb begin
      w_alu = '0;
      case (e_alu_op)
         4'd1:    w_alu = e_a + w_b;
         4'd2:    w_alu = e_a - w_b;
         4'd3:    w_alu = e_a & w_b;
         4'd4:    w_alu = e_a | w_lo16;
         4'd5:    w_alu = e_a ^ w_b;
         4'd6:    w_alu = w_lo16 << 16;
         4'd7:    w_alu = XLEN'($signed(e_a) < $signed(w_b));
         4'd8:    w_alu = XLEN'(e_a < w_b);
         4'd9:    w_alu = w_b << w_sh;
         4'd10:   w_alu = w_b >> w_sh;
         4'd11:   w_alu = $signed(w_b) >>> w_sh;
         4'd12:   w_alu = w_rotr;
         4'd13:   w_alu = w_clz;
         default: w_alu = '0;
      endcase
   end

   // ---------------- multiply / divide ----------------
   assign md_busy  = (r_state != S_IDLE);
   assign stall_e  = e_valid & md_busy & (e_md_op != 3'd0);
   assign w_accept = e_valid & ~stall_e;

   assign w_ext_a = {{XLEN{r_signed & r_op_a[XLEN-1]}}, r_op_a};
   assign w_ext_b = {{XLEN{r_signed & r_op_b[XLEN-1]}}, r_op_b};
   assign w_prod  = w_ext_a * w_ext_b;

   // Signed divide on magnitudes: quotient truncates toward zero, remainder takes dividend sign.
   assign w_neg_a   = r_signed & r_op_a[XLEN-1];
   assign w_neg_b   = r_signed & r_op_b[XLEN-1];
   assign w_mag_a   = w_neg_a ? -r_op_a : r_op_a;
   assign w_mag_b   = w_neg_b ? -r_op_b : r_op_b;
   assign w_div_den = (w_mag_b == '0) ? XLEN'(1) : w_mag_b;
   assign w_q_mag   = w_mag_a / w_div_den;
   assign w_r_mag   = w_mag_a % w_div_den;
   assign w_quot    = (w_neg_a ^ w_neg_b) ? -w_q_mag : w_q_mag;
   assign w_rem     = w_neg_a ? -w_r_mag : w_r_mag;

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_hi_nxt     = r_hi;
      w_lo_nxt     = r_lo;
      w_op_a_nxt   = r_op_a;
      w_op_b_nxt   = r_op_b;
      w_signed_nxt = r_signed;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               case (e_md_op)
                  3'd1, 3'd2: begin
                     w_state_nxt  = S_MUL;
                     w_cnt_nxt    = CW'(MUL_LAT - 1);
                     w_op_a_nxt   = e_a;
                     w_op_b_nxt   = e_b;
                     w_signed_nxt = (e_md_op == 3'd1);
                  end
                  3'd3, 3'd4: begin
                     w_state_nxt  = S_DIV;
                     w_cnt_nxt    = CW'(DIV_LAT - 1);
                     w_op_a_nxt   = e_a;
                     w_op_b_nxt   = e_b;
                     w_signed_nxt = (e_md_op == 3'd3);
                  end
                  3'd5:    w_hi_nxt = e_a;
                  3'd6:    w_lo_nxt = e_a;
                  default: ;
               endcase
            end
         end
         S_MUL: begin
            if (r_cnt == '0) begin
               {w_hi_nxt, w_lo_nxt} = w_prod;
               w_state_nxt          = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         S_DIV: begin
            if (r_cnt == '0) begin
               if (r_op_b == '0) begin
                  w_lo_nxt = '1;
                  w_hi_nxt = r_op_a;
               end else begin
                  w_lo_nxt = w_quot;
                  w_hi_nxt = w_rem;
               end
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_op_a   <= '0;
         r_op_b   <= '0;
         r_signed <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_hi     <= w_hi_nxt;
         r_lo     <= w_lo_nxt;
         r_op_a   <= w_op_a_nxt;
         r_op_b   <= w_op_b_nxt;
         r_signed <= w_signed_nxt;
      end
   end

   // ---------------- EX/MEM register ----------------
   // HI/LO land on the same edge md_busy falls, so an MFHI/MFLO released then reads the new value.
   assign w_result = (e_md_op == 3'd7) ? (e_md_hi ? r_hi : r_lo) : w_alu;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         m_valid  <= 1'b0;
         m_result <= '0;
         m_wdata  <= '0;
         m_wreg   <= '0;
         m_pc     <= '0;
      end else if (w_accept) begin
         m_valid  <= 1'b1;
         m_result <= w_result;
         m_wdata  <= e_b;
         m_wreg   <= e_wreg;
         m_pc     <= e_pc;
      end else begin
         m_valid  <= 1'b0;
         m_wreg   <= '0;
      end
   end

endmodule
